// File: rtl/pdp8_kw12_pkg.sv
// pdp8_kw12_pkg: shared definitions for the KW12 programmable real-time clock.
//   - IOT function codes carried in mb[2:0]
//   - counter mode encodings
//   - CPU major-state encodings used by the IOT decode window
//   - bit positions of the status readback word and of the CLEN control word
package pdp8_kw12_pkg;

  typedef enum logic [2:0] {
    FN_NOP  = 3'd0,
    FN_CLEN = 3'd1,
    FN_CLCF = 3'd2,
    FN_CLSK = 3'd3,
    FN_CLLB = 3'd4,
    FN_CLRC = 3'd5,
    FN_CLRS = 3'd6,
    FN_CLRB = 3'd7
  } iot_fn_e;

  // MODE_RSVD behaves exactly like MODE_FREE.
  typedef enum logic [1:0] {
    MODE_FREE   = 2'd0,
    MODE_REPEAT = 2'd1,
    MODE_SINGLE = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  localparam logic [3:0] ST_F0 = 4'd0;
  localparam logic [3:0] ST_F1 = 4'd1;
  localparam logic [3:0] ST_F2 = 4'd2;
  localparam logic [3:0] ST_F3 = 4'd3;

  // Status word (CLRS): {flag, ovr, run, int_en, mode[1:0], rate[1:0], 4'b0}
  localparam int STS_FLAG    = 11;
  localparam int STS_OVR     = 10;
  localparam int STS_RUN     = 9;
  localparam int STS_INTEN   = 8;
  localparam int STS_MODE_LO = 6;
  localparam int STS_RATE_LO = 4;

  // Control word (CLEN): {int_en, run, mode[1:0], rate[1:0], unused[5:0]}
  localparam int CTL_INTEN   = 11;
  localparam int CTL_RUN     = 10;
  localparam int CTL_MODE_LO = 8;
  localparam int CTL_RATE_LO = 6;

endpackage

// File: rtl/pdp8_kw12_prescale.sv
// pdp8_kw12_prescale: free-running prescaler that produces the counter tick.
//   clk, reset : CPU clock, synchronous active-high reset
//   run        : counting enabled; the prescaler holds while run is low
//   clr        : clear the prescaler (asserted when run goes 0->1)
//   rate       : tick every 2^(BASE_LOG2+2*rate) clocks
//   tick       : one-cycle pulse, high in the cycle the selected low bits are all ones
module pdp8_kw12_prescale #(
  parameter int BASE_LOG2 = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       clr,
  input  logic [1:0] rate,
  output logic       tick
);

  localparam int PW = BASE_LOG2 + 6;

  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] mask;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (run)
      cnt_d = cnt_q + PW'(1);
  end

  // Low BASE_LOG2+2*rate bits select the tick period; an empty mask
  // (BASE_LOG2=0, rate 0) ticks every clock.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PW; i++)
      if (i < BASE_LOG2 + 2 * int'(rate))
        mask[i] = 1'b1;
  end

  assign tick = run && ((cnt_q & mask) == mask);

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pdp8_kw12.sv
// pdp8_kw12: programmable real-time clock on the PDP-8 IOT bus.
//   clk, reset     : CPU clock, synchronous active-high reset
//   iot, state, mb : IOT in progress, CPU major state, instruction (mb[2:0] = function)
//   io_select      : device code of the instruction (matched against DEV)
//   io_data_in     : AC contents for CLEN/CLLB
//   io_data_out    : readback (CLRC counter, CLRS status), else 0
//   io_data_avail  : io_data_out valid for the AC
//   io_selected    : device addressed (F1 && iot && io_select==DEV)
//   io_interrupt   : int_en && flag
//   io_skip        : CLSK with flag set
module pdp8_kw12
  import pdp8_kw12_pkg::*;
#(
  parameter logic [5:0] DEV       = 6'o13,
  parameter int         CTR_W     = 12,
  parameter int         BASE_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iot,
  input  logic [3:0]  state,
  input  logic [11:0] mb,
  input  logic [5:0]  io_select,
  input  logic [11:0] io_data_in,
  output logic [11:0] io_data_out,
  output logic        io_data_avail,
  output logic        io_selected,
  output logic        io_interrupt,
  output logic        io_skip
);

  logic [CTR_W-1:0] ctr_q, ctr_d, buf_q, buf_d;
  logic             flag_q, flag_d, ovr_q, ovr_d;
  logic             run_q, run_d, int_en_q, int_en_d;
  mode_e            mode_q, mode_d;
  logic [1:0]       rate_q, rate_d;

  logic sel;
  logic do_clen, do_clcf, do_clsk, do_cllb, do_clrc, do_clrs, do_clrb;
  logic tick, tick_eff, wrap, pre_clr;
  logic [11:0] status;

  assign sel     = (state == ST_F1) && iot && (io_select == DEV);
  assign do_clen = sel && (mb[2:0] == FN_CLEN);
  assign do_clcf = sel && (mb[2:0] == FN_CLCF);
  assign do_clsk = sel && (mb[2:0] == FN_CLSK);
  assign do_cllb = sel && (mb[2:0] == FN_CLLB);
  assign do_clrc = sel && (mb[2:0] == FN_CLRC);
  assign do_clrs = sel && (mb[2:0] == FN_CLRS);
  assign do_clrb = sel && (mb[2:0] == FN_CLRB);

  assign pre_clr = do_clen && !run_q && io_data_in[CTL_RUN];

  pdp8_kw12_prescale #(.BASE_LOG2(BASE_LOG2)) u_prescale (
    .clk   (clk),
    .reset (reset),
    .run   (run_q),
    .clr   (pre_clr),
    .rate  (rate_q),
    .tick  (tick)
  );

  // A counter load/clear or a CLEN that stops the clock swallows the tick.
  assign tick_eff = tick && !do_cllb && !do_clrb && !(do_clen && !io_data_in[CTL_RUN]);
  assign wrap     = tick_eff && (&ctr_q);

  always_comb begin
    ctr_d    = ctr_q;
    buf_d    = buf_q;
    flag_d   = flag_q;
    ovr_d    = ovr_q;
    run_d    = run_q;
    int_en_d = int_en_q;
    mode_d   = mode_q;
    rate_d   = rate_q;

    if (do_clen) begin
      int_en_d = io_data_in[CTL_INTEN];
      run_d    = io_data_in[CTL_RUN];
      mode_d   = mode_e'(io_data_in[CTL_MODE_LO +: 2]);
      rate_d   = io_data_in[CTL_RATE_LO +: 2];
    end
    if (do_cllb) begin
      buf_d = io_data_in[CTR_W-1:0];
      ctr_d = io_data_in[CTR_W-1:0];
    end
    if (do_clrb)
      ctr_d = '0;

    if (tick_eff) begin
      if (wrap) begin
        case (mode_q)
          MODE_REPEAT: ctr_d = buf_q;
          MODE_SINGLE: begin
            ctr_d = buf_q;
            run_d = 1'b0;
          end
          default:     ctr_d = '0;
        endcase
      end else begin
        ctr_d = ctr_q + CTR_W'(1);
      end
    end

    // Wrap outranks CLCF; a CLCF coinciding with a wrap leaves ovr alone.
    if (wrap) begin
      flag_d = 1'b1;
      if (!do_clcf)
        ovr_d = ovr_q | flag_q;
    end else if (do_clcf) begin
      flag_d = 1'b0;
      ovr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_q    <= '0;
      buf_q    <= '0;
      flag_q   <= 1'b0;
      ovr_q    <= 1'b0;
      run_q    <= 1'b0;
      int_en_q <= 1'b0;
      mode_q   <= MODE_FREE;
      rate_q   <= 2'd0;
    end else begin
      ctr_q    <= ctr_d;
      buf_q    <= buf_d;
      flag_q   <= flag_d;
      ovr_q    <= ovr_d;
      run_q    <= run_d;
      int_en_q <= int_en_d;
      mode_q   <= mode_d;
      rate_q   <= rate_d;
    end
  end

  always_comb begin
    status = '0;
    status[STS_FLAG]           = flag_q;
    status[STS_OVR]            = ovr_q;
    status[STS_RUN]            = run_q;
    status[STS_INTEN]          = int_en_q;
    status[STS_MODE_LO +: 2]   = mode_q;
    status[STS_RATE_LO +: 2]   = rate_q;
  end

  always_comb begin
    io_data_out = '0;
    if (do_clrc)
      io_data_out = 12'(ctr_q);
    else if (do_clrs)
      io_data_out = status;
  end

  assign io_data_avail = do_clrc || do_clrs;
  assign io_selected   = sel;
  assign io_skip       = do_clsk && flag_q;
  assign io_interrupt  = int_en_q && flag_q;

endmodule

// File: tb/tb_pdp8_kw12.sv
module tb_pdp8_kw12;
  import pdp8_kw12_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iot = 1'b0;
  logic [3:0]  state = ST_F0;
  logic [11:0] mb = '0;
  logic [5:0]  io_select = '0;
  logic [11:0] io_data_in = '0;
  logic [11:0] io_data_out;
  logic        io_data_avail, io_selected, io_interrupt, io_skip;

  int errors = 0;
  int checks = 0;
  int edges  = 0;

  logic [11:0] obs_out;
  logic        obs_avail, obs_sel, obs_skip;

  pdp8_kw12 dut (
    .clk           (clk),
    .reset         (reset),
    .iot           (iot),
    .state         (state),
    .mb            (mb),
    .io_select     (io_select),
    .io_data_in    (io_data_in),
    .io_data_out   (io_data_out),
    .io_data_avail (io_data_avail),
    .io_selected   (io_selected),
    .io_interrupt  (io_interrupt),
    .io_skip       (io_skip)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One IOT: drive the F1 window for one cycle, capture combinational outputs,
  // and let the closing edge apply it.
  task automatic do_iot(input logic [2:0] fn, input logic [11:0] ac);
    @(negedge clk);
    state = ST_F1; iot = 1'b1; io_select = 6'o13; mb = {9'd0, fn}; io_data_in = ac;
    #1;
    obs_out = io_data_out; obs_avail = io_data_avail; obs_sel = io_selected; obs_skip = io_skip;
    @(posedge clk); edges++;
    #1;
    state = ST_F0; iot = 1'b0; io_select = '0; mb = '0; io_data_in = '0;
  endtask

  task automatic idle_to(input int target);
    while (edges < target) begin
      @(posedge clk); edges++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin @(posedge clk); edges++; end
    #1 reset = 1'b0;
    checks++;
    if ({io_data_out, io_data_avail, io_selected, io_interrupt, io_skip} !== 16'h0) begin
      errors++; $display("FAIL reset_outputs: got out=%o avail=%b sel=%b int=%b skip=%b, want all 0",
                         io_data_out, io_data_avail, io_selected, io_interrupt, io_skip);
    end
    do_iot(FN_CLRS, 12'o0);
    checks++;
    if (obs_out !== 12'o0000 || obs_avail !== 1'b1 || obs_sel !== 1'b1) begin
      errors++; $display("FAIL reset_clrs: got out=%o avail=%b sel=%b, want 0000 1 1", obs_out, obs_avail, obs_sel);
    end
    checks++;
    if (io_interrupt !== 1'b0) begin
      errors++; $display("FAIL reset_int: got %b want 0", io_interrupt);
    end
    // Wrong device code
    @(negedge clk);
    state = ST_F1; iot = 1'b1; io_select = 6'o14; mb = {9'd0, FN_CLRS};
    #1;
    checks++;
    if (io_selected !== 1'b0 || io_data_avail !== 1'b0) begin
      errors++; $display("FAIL wrong_dev: got sel=%b avail=%b want 0 0", io_selected, io_data_avail);
    end
    // Right device code, wrong major state
    state = ST_F0; io_select = 6'o13;
    #1;
    checks++;
    if (io_selected !== 1'b0 || io_data_out !== 12'o0) begin
      errors++; $display("FAIL wrong_state: got sel=%b out=%o want 0 0000", io_selected, io_data_out);
    end
    @(posedge clk); edges++;
    #1 iot = 1'b0; io_select = '0; mb = '0;
  endtask

  task automatic test_free_run();
    int e0;
    do_iot(FN_CLLB, 12'o7774);
    do_iot(FN_CLEN, 12'o6000);
    e0 = edges;
    idle_to(e0 + 31);
    checks++;
    if (io_interrupt !== 1'b0) begin
      errors++; $display("FAIL free_early_int: got %b want 0 one clock before 4th tick", io_interrupt);
    end
    idle_to(e0 + 32);
    checks++;
    if (io_interrupt !== 1'b1) begin
      errors++; $display("FAIL free_wrap_int: got %b want 1 at 4th tick", io_interrupt);
    end
    do_iot(FN_CLRC, 12'o0);
    checks++;
    if (obs_out !== 12'o0000 || obs_avail !== 1'b1) begin
      errors++; $display("FAIL free_ctr: got %o avail=%b want 0000 1", obs_out, obs_avail);
    end
    do_iot(FN_CLSK, 12'o0);
    checks++;
    if (obs_skip !== 1'b1) begin
      errors++; $display("FAIL free_skip: got %b want 1", obs_skip);
    end
    do_iot(FN_CLEN, 12'o0);
    do_iot(FN_CLCF, 12'o0);
  endtask

  task automatic test_repeat();
    int e0;
    do_iot(FN_CLLB, 12'o7776);
    do_iot(FN_CLEN, 12'o6500);  // int_en, run, repeat, rate 1
    e0 = edges;
    idle_to(e0 + 32);
    do_iot(FN_CLRC, 12'o0);
    checks++;
    if (obs_out !== 12'o7777) begin
      errors++; $display("FAIL rep_first_tick: got %o want 7777", obs_out);
    end
    idle_to(e0 + 63);
    checks++;
    if (io_interrupt !== 1'b0) begin
      errors++; $display("FAIL rep_early_int: got %b want 0", io_interrupt);
    end
    idle_to(e0 + 64);
    checks++;
    if (io_interrupt !== 1'b1) begin
      errors++; $display("FAIL rep_wrap_int: got %b want 1", io_interrupt);
    end
    do_iot(FN_CLRC, 12'o0);
    checks++;
    if (obs_out !== 12'o7776) begin
      errors++; $display("FAIL rep_reload: got %o want 7776", obs_out);
    end
    do_iot(FN_CLCF, 12'o0);
    do_iot(FN_CLSK, 12'o0);
    checks++;
    if (obs_skip !== 1'b0 || io_interrupt !== 1'b0) begin
      errors++; $display("FAIL rep_clcf: got skip=%b int=%b want 0 0", obs_skip, io_interrupt);
    end
    idle_to(e0 + 127);
    checks++;
    if (io_interrupt !== 1'b0) begin
      errors++; $display("FAIL rep_second_early: got %b want 0", io_interrupt);
    end
    idle_to(e0 + 128);
    checks++;
    if (io_interrupt !== 1'b1) begin
      errors++; $display("FAIL rep_second_wrap: got %b want 1", io_interrupt);
    end
    do_iot(FN_CLEN, 12'o0);
    do_iot(FN_CLCF, 12'o0);
  endtask

  task automatic test_single();
    int e0;
    do_iot(FN_CLLB, 12'o7777);
    do_iot(FN_CLEN, 12'o3000);  // run, single-shot, rate 0, no interrupt
    e0 = edges;
    idle_to(e0 + 7);
    do_iot(FN_CLRS, 12'o0);
    checks++;
    if (obs_out !== 12'o1200) begin
      errors++; $display("FAIL single_pre_status: got %o want 1200", obs_out);
    end
    do_iot(FN_CLRS, 12'o0);
    checks++;
    if (obs_out !== 12'o4200) begin
      errors++; $display("FAIL single_post_status: got %o want 4200", obs_out);
    end
    checks++;
    if (io_interrupt !== 1'b0) begin
      errors++; $display("FAIL single_int_masked: got %b want 0", io_interrupt);
    end
    idle_to(e0 + 100);
    do_iot(FN_CLRC, 12'o0);
    checks++;
    if (obs_out !== 12'o7777) begin
      errors++; $display("FAIL single_hold: got %o want 7777", obs_out);
    end
    do_iot(FN_CLRS, 12'o0);
    checks++;
    if (obs_out[9] !== 1'b0 || obs_out !== 12'o4200) begin
      errors++; $display("FAIL single_run_bit: got %o want 4200", obs_out);
    end
  endtask

  task automatic test_overflow_and_collisions();
    int e0;
    do_iot(FN_CLCF, 12'o0);
    do_iot(FN_CLLB, 12'o7777);
    do_iot(FN_CLEN, 12'o6400);  // int_en, run, repeat, rate 0: every tick wraps
    e0 = edges;
    idle_to(e0 + 8);
    checks++;
    if (io_interrupt !== 1'b1) begin
      errors++; $display("FAIL ovr_first_wrap: got %b want 1", io_interrupt);
    end
    idle_to(e0 + 16);
    do_iot(FN_CLRS, 12'o0);
    checks++;
    if (obs_out !== 12'o7500) begin
      errors++; $display("FAIL ovr_status: got %o want 7500", obs_out);
    end
    idle_to(e0 + 23);
    do_iot(FN_CLCF, 12'o0);     // lands on the wrap at e0+24
    do_iot(FN_CLRS, 12'o0);
    checks++;
    if (obs_out !== 12'o7500) begin
      errors++; $display("FAIL clcf_in_wrap: got %o want 7500", obs_out);
    end
    do_iot(FN_CLCF, 12'o0);
    do_iot(FN_CLRS, 12'o0);
    checks++;
    if (obs_out !== 12'o1500 || io_interrupt !== 1'b0) begin
      errors++; $display("FAIL clcf_plain: got %o int=%b want 1500 0", obs_out, io_interrupt);
    end
    idle_to(e0 + 31);
    do_iot(FN_CLLB, 12'o0005);  // coincides with tick at e0+32 that would wrap
    do_iot(FN_CLRC, 12'o0);
    checks++;
    if (obs_out !== 12'o0005 || io_interrupt !== 1'b0) begin
      errors++; $display("FAIL cllb_vs_tick: got %o int=%b want 0005 0", obs_out, io_interrupt);
    end
    idle_to(e0 + 39);
    do_iot(FN_CLRB, 12'o0);     // coincides with tick at e0+40
    do_iot(FN_CLRC, 12'o0);
    checks++;
    if (obs_out !== 12'o0000) begin
      errors++; $display("FAIL clrb_vs_tick: got %o want 0000", obs_out);
    end
    idle_to(e0 + 47);
    do_iot(FN_CLEN, 12'o4400);  // stop in the tick cycle at e0+48
    do_iot(FN_CLRC, 12'o0);
    checks++;
    if (obs_out !== 12'o0000) begin
      errors++; $display("FAIL stop_vs_tick: got %o want 0000", obs_out);
    end
  endtask

  task automatic test_reset_mid_count();
    int e1;
    do_iot(FN_CLLB, 12'o7777);
    do_iot(FN_CLEN, 12'o6400);
    e1 = edges;
    idle_to(e1 + 15);
    checks++;
    if (io_interrupt !== 1'b1) begin
      errors++; $display("FAIL mid_pre_int: got %b want 1", io_interrupt);
    end
    @(negedge clk);
    reset = 1'b1;               // edge e1+16 would be another wrap
    @(posedge clk); edges++;
    #1 reset = 1'b0;
    checks++;
    if ({io_data_out, io_data_avail, io_selected, io_interrupt, io_skip} !== 16'h0) begin
      errors++; $display("FAIL mid_reset_outputs: got out=%o avail=%b sel=%b int=%b skip=%b, want all 0",
                         io_data_out, io_data_avail, io_selected, io_interrupt, io_skip);
    end
    do_iot(FN_CLRC, 12'o0);
    checks++;
    if (obs_out !== 12'o0000) begin
      errors++; $display("FAIL mid_ctr: got %o want 0000", obs_out);
    end
    do_iot(FN_CLRS, 12'o0);
    checks++;
    if (obs_out !== 12'o0000) begin
      errors++; $display("FAIL mid_status: got %o want 0000", obs_out);
    end
    idle_to(edges + 64);
    do_iot(FN_CLRC, 12'o0);
    checks++;
    if (obs_out !== 12'o0000 || io_interrupt !== 1'b0) begin
      errors++; $display("FAIL mid_no_tick: got %o int=%b want 0000 0", obs_out, io_interrupt);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_repeat();
    test_single();
    test_overflow_and_collisions();
    test_reset_mid_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
